// File: rtl/router_pkg.sv
// Shared types and helpers for the store-and-forward router.
// Holds the FSM state encoding and header field sizing.
package router_pkg;

    typedef enum logic [2:0] {
        IDLE,
        WAIT_SPACE,
        LOAD,
        PARITY,
        DROP
    } state_e;

    // Destination field is never narrower than one bit.
    function automatic int dest_w(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/router_cfifo.sv
// Commit/rollback channel FIFO with speculative write pointer,
// committed-data visibility and an unread-data timeout flush.
module router_cfifo
    import router_pkg::*;
#(
    parameter int DW      = 8,
    parameter int DEPTH   = 8,
    parameter int TIMEOUT = 30
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      wr_en,
    input  logic [DW-1:0]             wr_data,
    input  logic                      commit,
    input  logic                      rollback,
    input  logic                      rd_en,
    output logic [$clog2(DEPTH):0]    free,
    output logic                      vld,
    output logic [DW-1:0]             dout,
    output logic                      timeout
);

    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;
    localparam int CW = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] TO_LAST = CW'(TIMEOUT - 1);

    logic [DW-1:0] mem_q [DEPTH];
    logic [PW-1:0] wr_q, wr_d;
    logic [PW-1:0] cmt_q, cmt_d;
    logic [PW-1:0] rd_q, rd_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          to_q, to_d;

    assign free    = PW'(DEPTH) - (wr_q - rd_q);
    assign vld     = (cmt_q != rd_q);
    assign dout    = vld ? mem_q[rd_q[AW-1:0]] : '0;
    assign timeout = to_q;

    always_comb begin
        wr_d  = wr_q;
        cmt_d = cmt_q;
        rd_d  = rd_q;
        cnt_d = cnt_q;
        to_d  = 1'b0;
        if (wr_en)
            wr_d = wr_q + PW'(1);
        if (commit)
            cmt_d = wr_q;
        if (rollback)
            wr_d = cmt_q;
        // Flush only drops committed bytes; an in-flight packet survives.
        if (!vld || rd_en) begin
            cnt_d = '0;
        end else if (cnt_q == TO_LAST) begin
            cnt_d = '0;
            rd_d  = cmt_q;
            to_d  = 1'b1;
        end else begin
            cnt_d = cnt_q + CW'(1);
        end
        if (rd_en && vld)
            rd_d = rd_q + PW'(1);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_q  <= '0;
            cmt_q <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
            to_q  <= 1'b0;
        end else begin
            wr_q  <= wr_d;
            cmt_q <= cmt_d;
            rd_q  <= rd_d;
            cnt_q <= cnt_d;
            to_q  <= to_d;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en)
            mem_q[wr_q[AW-1:0]] <= wr_data;
    end

endmodule

// File: rtl/router_sf_param.sv
// Store-and-forward packet router: header/data/parity input stream
// steered to NUM_CH commit/rollback FIFOs.
module router_sf_param
    import router_pkg::*;
#(
    parameter int NUM_CH  = 3,
    parameter int DW      = 8,
    parameter int DEPTH   = 8,
    parameter int TIMEOUT = 30
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 pkt_valid,
    input  logic [DW-1:0]        data_in,
    output logic                 busy,
    input  logic [NUM_CH-1:0]    rd_en,
    output logic [NUM_CH-1:0]    vld_out,
    output logic [NUM_CH*DW-1:0] data_out,
    output logic                 err,
    output logic                 pkt_ok,
    output logic [NUM_CH-1:0]    timeout
);

    localparam int DEST_W = dest_w(NUM_CH);
    localparam int LW     = DW - DEST_W;
    localparam int PW     = $clog2(DEPTH) + 1;
    localparam int CMPW   = ((LW > PW) ? LW : PW) + 1;

    state_e            state_q, state_d;
    logic [DEST_W-1:0] dest_q, dest_d;
    logic [LW-1:0]     len_q, len_d;
    logic [LW-1:0]     cnt_q, cnt_d;
    logic [DW-1:0]     par_q, par_d;
    logic              err_q, err_d;
    logic              ok_q, ok_d;

    logic [NUM_CH-1:0] wr_en, cmt, rb;
    logic [PW-1:0]     free_w [NUM_CH];
    logic [DEST_W-1:0] hdr_dest;
    logic [LW-1:0]     hdr_len;
    logic [PW-1:0]     hdr_free, sel_free;
    logic              hdr_bad_dest;
    logic [NUM_CH-1:0] dest_oh;

    assign hdr_dest = data_in[DEST_W-1:0];
    assign hdr_len  = data_in[DW-1:DEST_W];
    assign dest_oh  = NUM_CH'(1) << dest_q;
    assign err      = err_q;
    assign pkt_ok   = ok_q;

    // Free-space lookup without indexing past the last channel.
    always_comb begin
        hdr_free     = '0;
        sel_free     = '0;
        hdr_bad_dest = 1'b1;
        for (int i = 0; i < NUM_CH; i++) begin
            if (hdr_dest == DEST_W'(i)) begin
                hdr_free     = free_w[i];
                hdr_bad_dest = 1'b0;
            end
            if (dest_q == DEST_W'(i))
                sel_free = free_w[i];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            dest_q  <= '0;
            len_q   <= '0;
            cnt_q   <= '0;
            par_q   <= '0;
            err_q   <= 1'b0;
            ok_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            dest_q  <= dest_d;
            len_q   <= len_d;
            cnt_q   <= cnt_d;
            par_q   <= par_d;
            err_q   <= err_d;
            ok_q    <= ok_d;
        end
    end

    always_comb begin
        state_d = state_q;
        dest_d  = dest_q;
        len_d   = len_q;
        cnt_d   = cnt_q;
        par_d   = par_q;
        unique case (state_q)
            IDLE: begin
                if (pkt_valid) begin
                    dest_d = hdr_dest;
                    len_d  = hdr_len;
                    par_d  = data_in;
                    cnt_d  = '0;
                    if (hdr_bad_dest || hdr_len == '0 ||
                        CMPW'(hdr_len) > CMPW'(DEPTH))
                        state_d = DROP;
                    else if (CMPW'(hdr_free) < CMPW'(hdr_len))
                        state_d = WAIT_SPACE;
                    else
                        state_d = LOAD;
                end
            end
            WAIT_SPACE: begin
                if (!pkt_valid)
                    state_d = IDLE;
                else if (CMPW'(sel_free) >= CMPW'(len_q))
                    state_d = LOAD;
            end
            LOAD: begin
                if (!pkt_valid) begin
                    state_d = IDLE;
                end else begin
                    par_d = par_q ^ data_in;
                    cnt_d = cnt_q + LW'(1);
                    if (cnt_q == len_q - LW'(1))
                        state_d = PARITY;
                end
            end
            PARITY: state_d = IDLE;
            DROP: begin
                if (!pkt_valid)
                    state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        busy  = 1'b0;
        wr_en = '0;
        cmt   = '0;
        rb    = '0;
        err_d = 1'b0;
        ok_d  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (pkt_valid && (hdr_bad_dest || hdr_len == '0 ||
                    CMPW'(hdr_len) > CMPW'(DEPTH)))
                    err_d = 1'b1;
            end
            WAIT_SPACE: busy = 1'b1;
            LOAD: begin
                if (!pkt_valid) begin
                    rb    = dest_oh;
                    err_d = 1'b1;
                end else begin
                    wr_en = dest_oh;
                end
            end
            PARITY: begin
                if (pkt_valid && data_in == par_q) begin
                    cmt  = dest_oh;
                    ok_d = 1'b1;
                end else begin
                    rb    = dest_oh;
                    err_d = 1'b1;
                end
            end
            DROP: ;
            default: ;
        endcase
    end

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        router_cfifo #(
            .DW      (DW),
            .DEPTH   (DEPTH),
            .TIMEOUT (TIMEOUT)
        ) u_fifo (
            .clk      (clk),
            .rst      (rst),
            .wr_en    (wr_en[g]),
            .wr_data  (data_in),
            .commit   (cmt[g]),
            .rollback (rb[g]),
            .rd_en    (rd_en[g]),
            .free     (free_w[g]),
            .vld      (vld_out[g]),
            .dout     (data_out[g*DW +: DW]),
            .timeout  (timeout[g])
        );
    end

endmodule

// File: tb/tb_router_sf_param.sv
// Directed bench for router_sf_param with hand-computed vectors.
// Inputs change 1ns after posedge; pulse counts sampled on negedge.
module tb_router_sf_param;

    logic        clk = 1'b0;
    logic        rst;
    logic        pkt_valid;
    logic [7:0]  data_in;
    logic        busy;
    logic [2:0]  rd_en;
    logic [2:0]  vld_out;
    logic [23:0] data_out;
    logic        err;
    logic        pkt_ok;
    logic [2:0]  timeout;

    int checks = 0;
    int failures = 0;
    int n_err = 0;
    int n_ok = 0;
    int n_to2 = 0;
    int k;

    always #5 clk = ~clk;

    router_sf_param dut (
        .clk       (clk),
        .rst       (rst),
        .pkt_valid (pkt_valid),
        .data_in   (data_in),
        .busy      (busy),
        .rd_en     (rd_en),
        .vld_out   (vld_out),
        .data_out  (data_out),
        .err       (err),
        .pkt_ok    (pkt_ok),
        .timeout   (timeout)
    );

    always @(negedge clk) begin
        if (err) n_err++;
        if (pkt_ok) n_ok++;
        if (timeout[2]) n_to2++;
    end

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [7:0] b);
        int i;
        pkt_valid = 1'b1;
        data_in   = b;
        for (i = 0; i < 200; i++) begin
            @(negedge clk);
            if (!busy) break;
        end
        if (i == 200) chk("send_bound", 32'(busy), 32'd0);
        tick();
    endtask

    task automatic end_pkt();
        pkt_valid = 1'b0;
        data_in   = 8'h00;
    endtask

    task automatic pop(input int ch, input logic [7:0] exp);
        chk("pop_data", 32'(data_out[ch*8 +: 8]), 32'(exp));
        rd_en[ch] = 1'b1;
        tick();
        rd_en = '0;
    endtask

    initial begin
        rst = 1'b1;
        pkt_valid = 1'b0;
        data_in = 8'h00;
        rd_en = '0;
        tick();
        tick();
        rst = 1'b0;
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_vld", 32'(vld_out), 32'd0);
        chk("rst_dout", 32'(data_out), 32'd0);
        chk("rst_err", 32'(err), 32'd0);
        chk("rst_ok", 32'(pkt_ok), 32'd0);
        chk("rst_to", 32'(timeout), 32'd0);

        // Good packet to ch1
        send(8'h0D); send(8'h11); send(8'h22); send(8'h33); send(8'h0D);
        end_pkt();
        chk("good_ok", 32'(pkt_ok), 32'd1);
        chk("good_vld", 32'(vld_out), 32'b010);
        tick();
        chk("good_nok", 32'(n_ok), 32'd1);
        chk("good_nerr", 32'(n_err), 32'd0);
        pop(1, 8'h11); pop(1, 8'h22); pop(1, 8'h33);
        chk("good_empty", 32'(vld_out), 32'd0);
        chk("good_dout0", 32'(data_out), 32'd0);

        // Bad parity, then a good packet
        send(8'h0D); send(8'h11); send(8'h22); send(8'h33); send(8'h0C);
        end_pkt();
        chk("bad_err", 32'(err), 32'd1);
        chk("bad_vld", 32'(vld_out), 32'd0);
        tick();
        send(8'h0D); send(8'h44); send(8'h55); send(8'h66); send(8'h7A);
        end_pkt();
        chk("bad_next_ok", 32'(pkt_ok), 32'd1);
        tick();
        pop(1, 8'h44); pop(1, 8'h55); pop(1, 8'h66);
        chk("bad_nerr", 32'(n_err), 32'd1);

        // Truncation after two data bytes
        send(8'h0D); send(8'h11); send(8'h22);
        end_pkt();
        tick();
        chk("trunc_err", 32'(err), 32'd1);
        chk("trunc_vld", 32'(vld_out), 32'd0);

        // Illegal destination 3
        send(8'h0F); send(8'hAA); send(8'hBB);
        end_pkt();
        tick();
        tick();
        chk("ill_nerr", 32'(n_err), 32'd3);
        chk("ill_vld", 32'(vld_out), 32'd0);
        chk("ill_nok", 32'(n_ok), 32'd2);

        // Backpressure on ch0
        send(8'h18);
        for (int i = 1; i <= 6; i++) send(8'(i));
        send(8'h1F);
        end_pkt();
        tick();
        chk("bp_fill_vld", 32'(vld_out), 32'b001);
        send(8'h0C);
        pkt_valid = 1'b1;
        data_in = 8'hA1;
        chk("bp_busy", 32'(busy), 32'd1);
        tick();
        tick();
        chk("bp_busy_hold", 32'(busy), 32'd1);
        pop(0, 8'h01);
        for (k = 0; k < 10; k++) begin
            if (!busy) break;
            tick();
        end
        chk("bp_busy_drop", 32'(busy), 32'd0);
        send(8'hA1); send(8'hA2); send(8'hA3); send(8'hAC);
        end_pkt();
        chk("bp_ok", 32'(pkt_ok), 32'd1);
        tick();
        for (int i = 2; i <= 6; i++) pop(0, 8'(i));
        pop(0, 8'hA1); pop(0, 8'hA2); pop(0, 8'hA3);
        chk("bp_empty", 32'(vld_out), 32'd0);

        // Timeout flush on ch2
        send(8'h06); send(8'h55); send(8'h53);
        end_pkt();
        chk("to_vld", 32'(vld_out), 32'b100);
        for (k = 1; k <= 40; k++) begin
            tick();
            if (timeout[2]) break;
        end
        chk("to_cycles", 32'(k), 32'd30);
        chk("to_vld_off", 32'(vld_out), 32'd0);
        tick();
        chk("to_count", 32'(n_to2), 32'd1);

        // Pop in the last cycle before flush
        send(8'h06); send(8'h55); send(8'h53);
        end_pkt();
        for (int i = 0; i < 29; i++) tick();
        chk("to_nopop_vld", 32'(vld_out), 32'b100);
        pop(2, 8'h55);
        tick();
        tick();
        chk("to_noflush", 32'(n_to2), 32'd1);
        chk("to_empty", 32'(vld_out), 32'd0);

        // Reset mid-LOAD
        send(8'h0D); send(8'h11); send(8'h22);
        rst = 1'b1;
        end_pkt();
        tick();
        chk("rst_mid_vld", 32'(vld_out), 32'd0);
        chk("rst_mid_busy", 32'(busy), 32'd0);
        chk("rst_mid_err", 32'(err), 32'd0);
        chk("rst_mid_dout", 32'(data_out), 32'd0);
        rst = 1'b0;
        tick();
        send(8'h0D); send(8'h77); send(8'h88); send(8'h99); send(8'h6B);
        end_pkt();
        chk("post_rst_ok", 32'(pkt_ok), 32'd1);
        chk("post_rst_vld", 32'(vld_out), 32'b010);
        pop(1, 8'h77); pop(1, 8'h88); pop(1, 8'h99);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
